rf_scan_ctrl: RTL and testbench
===============================

Name: rf_scan_ctrl

Overview:
- Bulk-access initiator for the 32x32 register file. Drives the file's read and write ports.
- DUMP command: reads a contiguous register range and streams it out over a valid/ready interface.
- LOAD command: accepts a valid/ready input stream and writes it into a register range.
- Sits between the debug/test harness and the register file. Used for state save/restore and end-of-test checking.

Parameters:
- ADDR_WIDTH, 5, register address width.
- WORD_WIDTH, 32, register data width.
- REG_DEPTH, 32, number of registers (2**ADDR_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Synchronous, active-high. Sampled only on the clk rising edge.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0=DUMP, 1=LOAD.
- cmd_first  in  ADDR_WIDTH  first register index.
- cmd_last  in  ADDR_WIDTH  last register index, inclusive.
- rf_rd_addr  out  ADDR_WIDTH  read address to the register file.
- rf_rd_data  in  WORD_WIDTH  combinational read data returned for rf_rd_addr.
- rf_wr_addr  out  ADDR_WIDTH  write address.
- rf_wr_en  out  1  write strobe.
- rf_wr_data  out  WORD_WIDTH  write data.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  output sink ready.
- dout_data  out  WORD_WIDTH  register value.
- dout_addr  out  ADDR_WIDTH  index of dout_data.
- dout_last  out  1  final beat of the dump.
- din_valid  in  1  load beat valid.
- din_ready  out  1  high in LOAD.
- din_data  in  WORD_WIDTH  load word.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; ptr=0; remaining=0. Reset mid-command aborts immediately; no further rf_wr_en and no partial beat on dout.
- States: IDLE, DUMP, LOAD, plus CSUM under the optional feature.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready.
  - On accept: ptr=cmd_first; remaining=((cmd_last-cmd_first) mod REG_DEPTH)+1, range 1..32, held in a 6-bit counter.
  - Next state is DUMP or LOAD per cmd_op.
- Wrap-around: ptr increments mod REG_DEPTH. Example: first=30, last=1 covers 30,31,0,1 (4 words). first==last is a single word.
- DUMP:
  - rf_rd_addr=ptr combinationally.
  - The output register loads {rf_rd_data, ptr, remaining==1} when !dout_valid || dout_ready. It then asserts dout_valid, increments ptr and decrements remaining.
  - Held data is stable while dout_valid&&!dout_ready.
  - Throughput is 1 beat/cycle with dout_ready tied high.
  - Latency: command accepted at edge N, first dout_valid visible after edge N+1.
  - After the last beat is accepted: dout_valid=0, return to IDLE.
  - rf_wr_en is never asserted in DUMP.
- LOAD:
  - din_ready=1. Each din_valid&&din_ready beat drives rf_wr_en=1, rf_wr_addr=ptr, rf_wr_data=din_data for that cycle (combinational, same cycle). It then increments ptr and decrements remaining.
  - ptr==0: rf_wr_en is forced 0. The word is still consumed and counted, because register 0 is hardwired zero.
  - After the final beat: din_ready drops next cycle, return to IDLE.
  - din_valid=0 stalls with no writes.
- Commands arriving while busy are not accepted (cmd_ready=0).
- din is ignored outside LOAD. dout_ready is ignored when dout_valid=0.

Optional Feature:
- Macro: RF_SCAN_CHKSUM_EN.
- Defined:
  - A 32-bit running sum, mod 2^32, accumulates every word in both modes; it clears on command accept.
  - DUMP: after the last register beat, state CSUM emits one extra beat with dout_data=sum and dout_addr=0. dout_last moves to this checksum beat.
  - LOAD: the sum is exposed on an added output port chksum (WORD_WIDTH), valid when busy=0.
- Not defined: no CSUM state, no chksum port, no adder logic.

Decomposition:
- Shared package: ADDR_WIDTH, WORD_WIDTH, REG_DEPTH, OP_DUMP/OP_LOAD encodings, state encoding constants.
- One natural sub-module: rf_scan_outreg. It is the dout valid/ready holding register (data, addr, last), reused for the checksum beat.

Test Plan:
- Preload r1..r4=0x11,0x22,0x33,0x44. DUMP first=1 last=4, dout_ready=1 -> 4 consecutive beats 0x11..0x44, addr 1..4, dout_last on beat 4. First beat after edge N+1. Back in IDLE with cmd_ready=1.
- DUMP first=30 last=1 with dout_ready toggling 1,0,0,1 -> addr order 30,31,0,1. Data held stable during stalls. dout_addr 0 data=0.
- LOAD first=0 last=2, din=0xAAAA,0xBBBB,0xCCCC -> no write at addr 0. Writes r1=0xBBBB, r2=0xCCCC. Three din handshakes total.
- LOAD with din_valid gaps; cmd_valid pulsed while busy -> cmd not accepted, writes only on valid beats.
- Assert rst after 2 of 5 DUMP beats -> next cycle dout_valid=0, busy=0, cmd_ready=1, no further beats.
- With RF_SCAN_CHKSUM_EN defined: DUMP r1..r2 = 0xFFFFFFFF, 0x2 -> extra beat dout_data=0x00000001 with dout_last=1.

Source files
------------

// File: rtl/rf_scan_ctrl_pkg.sv
// Shared constants, opcodes and state encoding for the register-file scan controller.
// Optional checksum beat/port is enabled by defining RF_SCAN_CHKSUM_EN.
package rf_scan_ctrl_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int WORD_WIDTH = 32;
  localparam int REG_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  localparam logic OP_DUMP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

`ifdef RF_SCAN_CHKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_LOAD = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_LOAD = 2'd2
  } state_t;
`endif

  // Inclusive range length with wrap-around: 1..REG_DEPTH.
  function automatic logic [CNT_WIDTH-1:0] span_len(input logic [ADDR_WIDTH-1:0] first,
                                                    input logic [ADDR_WIDTH-1:0] last);
    logic [ADDR_WIDTH-1:0] diff;
    diff = last - first;
    return {1'b0, diff} + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rf_scan_outreg.sv
// Valid/ready holding register for the dump stream (data, index, last flag).
module rf_scan_outreg
  import rf_scan_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  ready,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  last_in,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  // The parent only asserts load when the register is empty or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      addr  <= addr_in;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_scan_ctrl.sv
// Bulk DUMP/LOAD initiator for the 32x32 register file.
// Define RF_SCAN_CHKSUM_EN to add the running checksum, CSUM beat and chksum port.
module rf_scan_ctrl
  import rf_scan_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_first,
  input  logic [ADDR_WIDTH-1:0] cmd_last,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [WORD_WIDTH-1:0] rf_rd_data,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic                  rf_wr_en,
  output logic [WORD_WIDTH-1:0] rf_wr_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [WORD_WIDTH-1:0] dout_data,
  output logic [ADDR_WIDTH-1:0] dout_addr,
  output logic                  dout_last,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [WORD_WIDTH-1:0] din_data,
`ifdef RF_SCAN_CHKSUM_EN
  output logic [WORD_WIDTH-1:0] chksum,
`endif
  output logic                  busy
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  accept, din_fire, out_room, dump_step;
  logic                  out_load, out_last;
  logic [WORD_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign din_ready  = (state == ST_LOAD);
  assign accept     = cmd_valid && cmd_ready;
  assign din_fire   = din_valid && din_ready;
  assign out_room   = !dout_valid || dout_ready;
  assign dump_step  = (state == ST_DUMP) && (remaining != '0) && out_room;
  assign rf_rd_addr = ptr;

  // Register 0 is hardwired zero, so its word is consumed without a write.
  assign rf_wr_en   = din_fire && (ptr != '0);
  assign rf_wr_addr = ptr;
  assign rf_wr_data = din_fire ? din_data : '0;

`ifdef RF_SCAN_CHKSUM_EN
  logic [WORD_WIDTH-1:0] sum;
  assign chksum = sum;
`endif

  always_comb begin
    next_state = state;
    out_load   = dump_step;
    out_data   = rf_rd_data;
    out_addr   = ptr;
`ifdef RF_SCAN_CHKSUM_EN
    out_last   = 1'b0;
`else
    out_last   = (remaining == CNT_WIDTH'(1));
`endif
    case (state)
      ST_IDLE: begin
        if (accept) next_state = (cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP;
      end
      ST_DUMP: begin
`ifdef RF_SCAN_CHKSUM_EN
        if ((remaining == '0) && out_room) begin
          out_load   = 1'b1;
          out_data   = sum;
          out_addr   = '0;
          out_last   = 1'b1;
          next_state = ST_CSUM;
        end
`else
        if ((remaining == '0) && dout_valid && dout_ready) next_state = ST_IDLE;
`endif
      end
`ifdef RF_SCAN_CHKSUM_EN
      ST_CSUM: begin
        if (dout_valid && dout_ready) next_state = ST_IDLE;
      end
`endif
      ST_LOAD: begin
        if (din_fire && (remaining == CNT_WIDTH'(1))) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
`ifdef RF_SCAN_CHKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state <= next_state;
      if (accept) begin
        ptr       <= cmd_first;
        remaining <= span_len(cmd_first, cmd_last);
`ifdef RF_SCAN_CHKSUM_EN
        sum       <= '0;
`endif
      end else if (dump_step || din_fire) begin
        ptr       <= ptr + ADDR_WIDTH'(1);
        remaining <= remaining - CNT_WIDTH'(1);
`ifdef RF_SCAN_CHKSUM_EN
        sum       <= sum + (din_fire ? din_data : rf_rd_data);
`endif
      end
    end
  end

  rf_scan_outreg u_outreg (
    .clk     (clk),
    .rst     (rst),
    .load    (out_load),
    .ready   (dout_ready),
    .data_in (out_data),
    .addr_in (out_addr),
    .last_in (out_last),
    .valid   (dout_valid),
    .data    (dout_data),
    .addr    (dout_addr),
    .last    (dout_last)
  );

endmodule

// File: tb/tb_rf_scan_ctrl.sv
// Directed self-checking bench for rf_scan_ctrl with a behavioural 32x32 register file.
// Also exercises the checksum beat when RF_SCAN_CHKSUM_EN is defined.
module tb_rf_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [4:0]  cmd_first, cmd_last;
  logic [4:0]  rf_rd_addr, rf_wr_addr;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic        rf_wr_en;
  logic        dout_valid, dout_ready, dout_last;
  logic [31:0] dout_data;
  logic [4:0]  dout_addr;
  logic        din_valid, din_ready;
  logic [31:0] din_data;
  logic        busy;
`ifdef RF_SCAN_CHKSUM_EN
  logic [31:0] chksum;
`endif

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int hs_cnt = 0;
  logic wr0_seen = 1'b0;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  rf_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_first  (cmd_first),
    .cmd_last   (cmd_last),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
`ifdef RF_SCAN_CHKSUM_EN
    .chksum     (chksum),
`endif
    .busy       (busy)
  );

  // Register file model: r0 reads as zero, writes land on the clock edge.
  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'h0 : rf_mem[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      rf_mem[rf_wr_addr] = rf_wr_data;
      wr_cnt = wr_cnt + 1;
      if (rf_wr_addr == 5'd0) wr0_seen = 1'b1;
    end
    if (din_valid && din_ready) hs_cnt = hs_cnt + 1;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic issue_cmd(input logic op, input logic [4:0] first, input logic [4:0] last);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_first = first;
    cmd_last  = last;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_last = '0;
    dout_ready = 1'b0; din_valid = 1'b0; din_data = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dout_valid, dout_data, dout_addr, dout_last, busy, din_ready, rf_wr_en, rf_rd_addr, rf_wr_addr} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h addr=%0d last=%b busy=%b din_ready=%b wr_en=%b required all zero",
               dout_valid, dout_data, dout_addr, dout_last, busy, din_ready, rf_wr_en);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL reset_idle: got cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_dump_basic();
    logic [31:0] ed [5];
    logic [4:0]  ea [5];
    logic        el [5];
    int nb;
    rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33; rf_mem[4] = 32'h44;
    ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33; ed[3] = 32'h44; ed[4] = 32'hAA;
    ea[0] = 5'd1; ea[1] = 5'd2; ea[2] = 5'd3; ea[3] = 5'd4; ea[4] = 5'd0;
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b0;
`ifdef RF_SCAN_CHKSUM_EN
    nb = 5; el[3] = 1'b0; el[4] = 1'b1;
`else
    nb = 4; el[3] = 1'b1; el[4] = 1'b0;
`endif
    dout_ready = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL dump_basic_cmd_ready: got %b required 1", cmd_ready);
    end
    issue_cmd(1'b0, 5'd1, 5'd4);
    total++;
    if ({dout_valid, busy, cmd_ready} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL dump_basic_latency: got valid/busy/cmd_ready=%b required 010", {dout_valid, busy, cmd_ready});
    end
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      total++;
      if ({dout_valid, dout_data, dout_addr, dout_last} !== {1'b1, ed[i], ea[i], el[i]}) begin
        bad++;
        $display("[TB] FAIL dump_basic_beat%0d: got v=%b d=%h a=%0d l=%b required v=1 d=%h a=%0d l=%b",
                 i, dout_valid, dout_data, dout_addr, dout_last, ed[i], ea[i], el[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if ({dout_valid, busy, cmd_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL dump_basic_done: got valid/busy/cmd_ready=%b required 001", {dout_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_dump_wrap();
    logic [31:0] ed [5];
    logic [4:0]  ea [5];
    logic        el [5];
    logic        pat [4];
    logic [31:0] held_d;
    logic [4:0]  held_a;
    logic        stalled;
    int nb, beat;
    rf_mem[30] = 32'h300; rf_mem[31] = 32'h310;
    ed[0] = 32'h300; ed[1] = 32'h310; ed[2] = 32'h0; ed[3] = 32'h11; ed[4] = 32'h621;
    ea[0] = 5'd30; ea[1] = 5'd31; ea[2] = 5'd0; ea[3] = 5'd1; ea[4] = 5'd0;
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b0;
`ifdef RF_SCAN_CHKSUM_EN
    nb = 5; el[3] = 1'b0; el[4] = 1'b1;
`else
    nb = 4; el[3] = 1'b1; el[4] = 1'b0;
`endif
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    dout_ready = 1'b1;
    issue_cmd(1'b0, 5'd30, 5'd1);
    beat = 0; stalled = 1'b0; held_d = '0; held_a = '0;
    for (int c = 0; c < 40 && beat < nb; c++) begin
      dout_ready = pat[c % 4];
      if (stalled) begin
        total++;
        if ({dout_valid, dout_data, dout_addr} !== {1'b1, held_d, held_a}) begin
          bad++;
          $display("[TB] FAIL dump_wrap_hold: got v=%b d=%h a=%0d required v=1 d=%h a=%0d",
                   dout_valid, dout_data, dout_addr, held_d, held_a);
        end
      end
      if (dout_valid && dout_ready) begin
        total++;
        if ({dout_data, dout_addr, dout_last} !== {ed[beat], ea[beat], el[beat]}) begin
          bad++;
          $display("[TB] FAIL dump_wrap_beat%0d: got d=%h a=%0d l=%b required d=%h a=%0d l=%b",
                   beat, dout_data, dout_addr, dout_last, ed[beat], ea[beat], el[beat]);
        end
        beat++;
      end
      stalled = dout_valid && !dout_ready;
      held_d  = dout_data;
      held_a  = dout_addr;
      @(posedge clk); #1;
    end
    total++;
    if (beat != nb || {dout_valid, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL dump_wrap_done: got beats=%0d valid=%b busy=%b required beats=%0d valid=0 busy=0",
               beat, dout_valid, busy, nb);
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_load_zero();
    logic [31:0] d [3];
    int wr_base, hs_base;
    d[0] = 32'hAAAA; d[1] = 32'hBBBB; d[2] = 32'hCCCC;
    wr_base = wr_cnt; hs_base = hs_cnt;
    issue_cmd(1'b1, 5'd0, 5'd2);
    total++;
    if ({din_ready, busy} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL load_zero_enter: got din_ready=%b busy=%b required 1 1", din_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din_data  = d[i];
      #1;
      total++;
      if ({rf_wr_en, rf_wr_addr} !== {(i != 0), 5'(i)}) begin
        bad++;
        $display("[TB] FAIL load_zero_write%0d: got en=%b addr=%0d required en=%b addr=%0d",
                 i, rf_wr_en, rf_wr_addr, (i != 0), i);
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    total++;
    if ({din_ready, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL load_zero_exit: got din_ready=%b busy=%b required 0 0", din_ready, busy);
    end
    total++;
    if (rf_mem[1] !== 32'hBBBB || rf_mem[2] !== 32'hCCCC || wr0_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_zero_contents: got r1=%h r2=%h wr0=%b required r1=0000bbbb r2=0000cccc wr0=0",
               rf_mem[1], rf_mem[2], wr0_seen);
    end
    total++;
    if ((wr_cnt - wr_base) != 2 || (hs_cnt - hs_base) != 3) begin
      bad++;
      $display("[TB] FAIL load_zero_counts: got writes=%0d handshakes=%0d required 2 3",
               wr_cnt - wr_base, hs_cnt - hs_base);
    end
`ifdef RF_SCAN_CHKSUM_EN
    total++;
    if (chksum !== 32'h23331) begin
      bad++;
      $display("[TB] FAIL load_zero_chksum: got %h required 00023331", chksum);
    end
`endif
  endtask

  task automatic test_load_gaps();
    logic        pv [6];
    logic [31:0] d [3];
    int k, wr_base;
    pv[0] = 1'b1; pv[1] = 1'b0; pv[2] = 1'b1; pv[3] = 1'b0; pv[4] = 1'b0; pv[5] = 1'b1;
    d[0] = 32'h55; d[1] = 32'h66; d[2] = 32'h77;
    wr_base = wr_cnt;
    issue_cmd(1'b1, 5'd5, 5'd7);
    k = 0;
    for (int s = 0; s < 6; s++) begin
      din_valid = pv[s];
      din_data  = pv[s] ? d[k] : (32'hBAD0_0000 + 32'(s));
      cmd_valid = (s == 1);
      cmd_op    = 1'b0; cmd_first = 5'd1; cmd_last = 5'd1;
      #1;
      total++;
      if ({cmd_ready, rf_wr_en} !== {1'b0, pv[s]} || (pv[s] && rf_wr_addr !== 5'(5 + k))) begin
        bad++;
        $display("[TB] FAIL load_gaps_step%0d: got cmd_ready=%b en=%b addr=%0d required cmd_ready=0 en=%b addr=%0d",
                 s, cmd_ready, rf_wr_en, rf_wr_addr, pv[s], 5 + k);
      end
      if (pv[s]) k++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    din_valid = 1'b0;
    total++;
    if ({busy, dout_valid} !== 2'b00 || (wr_cnt - wr_base) != 3) begin
      bad++;
      $display("[TB] FAIL load_gaps_exit: got busy=%b dout_valid=%b writes=%0d required 0 0 3",
               busy, dout_valid, wr_cnt - wr_base);
    end
    total++;
    if ({rf_mem[5], rf_mem[6], rf_mem[7]} !== {32'h55, 32'h66, 32'h77}) begin
      bad++;
      $display("[TB] FAIL load_gaps_contents: got r5=%h r6=%h r7=%h required 55 66 77",
               rf_mem[5], rf_mem[6], rf_mem[7]);
    end
  endtask

  task automatic test_reset_mid();
    int wr_base;
    logic extra;
    wr_base = wr_cnt;
    dout_ready = 1'b1;
    issue_cmd(1'b0, 5'd1, 5'd5);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({dout_valid, dout_addr} !== {1'b1, 5'(i)}) begin
        bad++;
        $display("[TB] FAIL reset_mid_beat%0d: got v=%b a=%0d required v=1 a=%0d", i, dout_valid, dout_addr, i);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({dout_valid, busy, cmd_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL reset_mid_abort: got valid/busy/cmd_ready=%b required 001", {dout_valid, busy, cmd_ready});
    end
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dout_valid || busy) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0 || wr_cnt != wr_base) begin
      bad++;
      $display("[TB] FAIL reset_mid_quiet: got late_activity=%b writes=%0d required 0 0", extra, wr_cnt - wr_base);
    end
  endtask

`ifdef RF_SCAN_CHKSUM_EN
  task automatic test_chksum();
    logic [31:0] ed [3];
    logic [4:0]  ea [3];
    logic        el [3];
    rf_mem[1] = 32'hFFFF_FFFF; rf_mem[2] = 32'h2;
    ed[0] = 32'hFFFF_FFFF; ed[1] = 32'h2; ed[2] = 32'h1;
    ea[0] = 5'd1; ea[1] = 5'd2; ea[2] = 5'd0;
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b1;
    dout_ready = 1'b1;
    issue_cmd(1'b0, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({dout_valid, dout_data, dout_addr, dout_last} !== {1'b1, ed[i], ea[i], el[i]}) begin
        bad++;
        $display("[TB] FAIL chksum_beat%0d: got v=%b d=%h a=%0d l=%b required v=1 d=%h a=%0d l=%b",
                 i, dout_valid, dout_data, dout_addr, dout_last, ed[i], ea[i], el[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if ({dout_valid, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL chksum_done: got valid=%b busy=%b required 0 0", dout_valid, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dump_basic();
    test_dump_wrap();
    test_load_zero();
    test_load_gaps();
    test_reset_mid();
`ifdef RF_SCAN_CHKSUM_EN
    test_chksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
